des_stream_buffer: RTL and testbench

- Sits between an upstream ready/valid block source and the free-running 16-stage DES pipeline, which has no backpressure.
- Admits blocks into the pipeline only when a result slot is guaranteed, using a credit scheme of FIFO occupancy plus in-flight count.
- Captures pipeline outputs into a first-word-fall-through FIFO drained by a ready/valid consumer.
- Flushes stale in-flight results after reset.

---
 rtl/des_stream_buffer.sv | 117 +++++++++++
 tb/tb_des_stream_buffer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/des_stream_buffer.sv
// Credit-gated stream buffer between a ready/valid source and a free-running
// DES pipeline. Results are captured into a first-word-fall-through FIFO
// drained by a ready/valid consumer. Stale pipeline output after reset is
// swallowed by a LATENCY-cycle flush window.
module des_stream_buffer #(
   parameter int DEPTH   = 32,
   parameter int LATENCY = 16
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic                         i_in_valid,
   output logic                         o_in_ready,
   input  logic [63:0]                  i_in_data,
   input  logic [63:0]                  i_in_key,
   input  logic                         i_in_encrypt,
   output logic [63:0]                  o_des_cleartext,
   output logic [63:0]                  o_des_key,
   output logic                         o_des_encrypt,
   output logic                         o_des_dv,
   input  logic [63:0]                  i_des_ciphertext,
   input  logic                         i_des_dv,
   output logic                         o_out_valid,
   input  logic                         i_out_ready,
   output logic [63:0]                  o_out_data,
   output logic [$clog2(DEPTH+1)-1:0]   o_count,
   output logic                         o_err
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int AW = $clog2(DEPTH);
   localparam int FW = $clog2(LATENCY + 1);

   logic [63:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic [CW-1:0] inflight;
   logic [FW-1:0] flush;
   logic          err;

   logic [CW:0]   credit_used;
   logic          flushing;
   logic          accept;
   logic          dv_live;
   logic          spurious;
   logic          pop;
   logic          wr_en;
   logic          drop;

   // Credit check, handshake and write/pop qualification from registered state
   always_comb begin
      flushing    = (flush != '0);
      credit_used = {1'b0, count} + {1'b0, inflight};
      o_in_ready  = !flushing && (credit_used < (CW+1)'(DEPTH));
      accept      = i_in_valid && o_in_ready;
      dv_live     = i_des_dv && !flushing;
      spurious    = dv_live && (inflight == '0);
      o_out_valid = (count != '0);
      pop         = o_out_valid && i_out_ready;
      wr_en       = dv_live && ((count < CW'(DEPTH)) || pop);
      drop        = dv_live && !wr_en;
   end

   // DES input passthrough and FIFO head presentation
   always_comb begin
      o_des_cleartext = i_in_data;
      o_des_key       = i_in_key;
      o_des_encrypt   = i_in_encrypt;
      o_des_dv        = accept;
      o_out_data      = mem[rd_ptr];
      o_count         = count;
      o_err           = err;
   end

   // Flush window, credits, pointers, occupancy and sticky error
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         flush    <= FW'(LATENCY);
         inflight <= '0;
         count    <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         err      <= 1'b0;
      end else begin
         if (flushing)
            flush <= flush - 1'b1;

         // a spurious valid never decrements, so accept alone may still count up
         case ({accept, dv_live && !spurious})
            2'b10:   inflight <= inflight + 1'b1;
            2'b01:   inflight <= inflight - 1'b1;
            default: inflight <= inflight;
         endcase

         case ({wr_en, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase

         if (wr_en)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;

         if (spurious || drop)
            err <= 1'b1;
      end
   end

   // Result storage; contents are only meaningful while counted
   always_ff @(posedge i_clk) begin
      if (wr_en)
         mem[wr_ptr] <= i_des_ciphertext;
   end

endmodule

// File: tb/tb_des_stream_buffer.sv
// Scoreboard bench for des_stream_buffer with a behavioural 16-stage DES
// stand-in (known vectors mapped explicitly, other blocks use a simple
// keyed transform) plus an injection port for unsolicited DES valids.
module tb_des_stream_buffer;

   localparam int DEPTH   = 32;
   localparam int LATENCY = 16;
   localparam int CW      = $clog2(DEPTH + 1);

   localparam logic [63:0] KAT_KEY = 64'h133457799BBCDFF1;
   localparam logic [63:0] KAT_PT  = 64'h0123456789ABCDEF;
   localparam logic [63:0] KAT_CT  = 64'h85E813540F0AB405;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [63:0]   in_data;
   logic [63:0]   in_key;
   logic          in_encrypt;
   logic [63:0]   des_cleartext;
   logic [63:0]   des_key;
   logic          des_encrypt;
   logic          des_dv;
   logic [63:0]   des_ciphertext;
   logic          des_out_dv;
   logic          out_valid;
   logic          out_ready;
   logic [63:0]   out_data;
   logic [CW-1:0] count;
   logic          err;

   logic          inj_dv;
   logic [63:0]   inj_data;

   int unsigned tests = 0;
   int unsigned fails = 0;
   int unsigned acc_cnt = 0;
   int unsigned pop_cnt = 0;
   logic [63:0] exp_q [$];
   logic [31:0] seq = 32'd0;

   always #5 clk = ~clk;

   des_stream_buffer #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
      .i_clk            (clk),
      .i_rst            (rst),
      .i_in_valid       (in_valid),
      .o_in_ready       (in_ready),
      .i_in_data        (in_data),
      .i_in_key         (in_key),
      .i_in_encrypt     (in_encrypt),
      .o_des_cleartext  (des_cleartext),
      .o_des_key        (des_key),
      .o_des_encrypt    (des_encrypt),
      .o_des_dv         (des_dv),
      .i_des_ciphertext (des_ciphertext),
      .i_des_dv         (des_out_dv),
      .o_out_valid      (out_valid),
      .i_out_ready      (out_ready),
      .o_out_data       (out_data),
      .o_count          (count),
      .o_err            (err)
   );

   function automatic logic [63:0] des_model(input logic [63:0] d, input logic [63:0] k,
                                             input logic e);
      if (k == KAT_KEY && e && d == KAT_PT)
         return KAT_CT;
      if (k == KAT_KEY && !e && d == KAT_CT)
         return KAT_PT;
      return d ^ k ^ (e ? 64'hFFFF_0000_FFFF_0000 : 64'h0000_FFFF_0000_FFFF);
   endfunction

   // Stand-in DES pipeline: never reset, so stale results survive a buffer reset
   logic [63:0] pd [LATENCY];
   logic        pv [LATENCY];
   initial begin
      for (int i = 0; i < LATENCY; i++) begin
         pd[i] = '0;
         pv[i] = 1'b0;
      end
   end
   always @(posedge clk) begin
      pv[0] <= des_dv;
      pd[0] <= des_model(des_cleartext, des_key, des_encrypt);
      for (int i = 1; i < LATENCY; i++) begin
         pv[i] <= pv[i-1];
         pd[i] <= pd[i-1];
      end
   end
   assign des_out_dv     = pv[LATENCY-1] | inj_dv;
   assign des_ciphertext = inj_dv ? inj_data : pd[LATENCY-1];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Monitor: record accepted blocks, and compare every popped result
   always @(negedge clk) begin
      if (!rst) begin
         if (in_valid && in_ready) begin
            exp_q.push_back(des_model(in_data, in_key, in_encrypt));
            acc_cnt++;
         end
         if (out_valid && out_ready) begin
            pop_cnt++;
            if (exp_q.size() == 0)
               check("unexpected_output", out_data, 64'hx);
            else
               check("result_order", out_data, exp_q.pop_front());
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      seq     = seq + 1;
      in_data = {32'hA5C3_0000, seq};
   endtask

   // Reset, then measure how many cycles until admission opens
   task automatic do_reset();
      int unsigned rise;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      rst      = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_q.delete();
      rise = 99;
      for (int unsigned k = 0; k <= 40; k++) begin
         @(negedge clk);
         if (k == 0) begin
            check("rst_in_ready", {63'd0, in_ready}, 64'd0);
            check("rst_out_valid", {63'd0, out_valid}, 64'd0);
            check("rst_count", {{(64-CW){1'b0}}, count}, 64'd0);
            check("rst_err", {63'd0, err}, 64'd0);
            check("rst_des_dv", {63'd0, des_dv}, 64'd0);
         end
         if (in_ready) begin
            rise = k;
            break;
         end
      end
      check("flush_ready_rise", 64'(rise), 64'd16);
   endtask

   task automatic wait_count(input int unsigned target, input string name);
      int unsigned n = 0;
      while (count != CW'(target) && n < 200) begin
         @(negedge clk);
         n++;
      end
      check(name, {{(64-CW){1'b0}}, count}, 64'(target));
   endtask

   initial begin
      int unsigned a0, p0, lat, gaps, maxc, win_pops, nvalid;
      rst        = 1'b0;
      in_valid   = 1'b0;
      in_data    = '0;
      in_key     = 64'h0F1E2D3C4B5A6978;
      in_encrypt = 1'b1;
      out_ready  = 1'b1;
      inj_dv     = 1'b0;
      inj_data   = '0;

      do_reset();

      // Known-answer encrypt with latency measurement, then decrypt
      @(posedge clk);
      #1;
      in_key = KAT_KEY; in_data = KAT_PT; in_encrypt = 1'b1; in_valid = 1'b1;
      @(negedge clk);
      check("kat_accept", {63'd0, in_ready}, 64'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = 99;
      for (int unsigned n = 1; n <= 40; n++) begin
         @(negedge clk);
         if (out_valid) begin
            lat = n;
            check("kat_data", out_data, KAT_CT);
            break;
         end
      end
      check("kat_latency", 64'(lat), 64'd17);
      @(posedge clk);
      #1;
      in_data = KAT_CT; in_encrypt = 1'b0; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      in_encrypt = 1'b1;
      in_key = 64'h0F1E2D3C4B5A6978;
      repeat (20) step();
      check("kat_decrypt_done", 64'(exp_q.size()), 64'd0);

      // Backpressure fill
      out_ready = 1'b0;
      a0 = acc_cnt;
      in_valid = 1'b1;
      repeat (80) step();
      @(negedge clk);
      check("fill_accepts", 64'(acc_cnt - a0), 64'd32);
      check("fill_ready_low", {63'd0, in_ready}, 64'd0);
      check("fill_count", {{(64-CW){1'b0}}, count}, 64'd32);
      check("fill_err", {63'd0, err}, 64'd0);
      step();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      p0 = pop_cnt;
      wait_count(0, "fill_drain_count");
      @(negedge clk);
      check("fill_drain_pops", 64'(pop_cnt - p0), 64'd32);
      check("fill_ready_back", {63'd0, in_ready}, 64'd1);

      // Full throughput window
      step();
      a0 = acc_cnt; p0 = pop_cnt; gaps = 0; maxc = 0; win_pops = 0;
      in_valid = 1'b1;
      for (int unsigned c = 0; c < 200; c++) begin
         @(negedge clk);
         if (!in_ready) gaps++;
         if (32'(count) > maxc) maxc = 32'(count);
         step();
      end
      in_valid = 1'b0;
      win_pops = pop_cnt - p0;
      repeat (25) step();
      check("tput_accepts", 64'(acc_cnt - a0), 64'd200);
      check("tput_gaps", 64'(gaps), 64'd0);
      check("tput_window_pops", 64'(win_pops), 64'd183);
      check("tput_total_pops", 64'(pop_cnt - p0), 64'd200);
      check("tput_max_count", 64'(maxc), 64'd1);

      // Reset with 10 blocks in flight
      a0 = acc_cnt;
      in_valid = 1'b1;
      while (acc_cnt - a0 < 10) step();
      in_valid = 1'b0;
      do_reset();
      nvalid = 0;
      for (int unsigned c = 0; c < 25; c++) begin
         @(negedge clk);
         if (out_valid) nvalid++;
      end
      check("midrst_no_output", 64'(nvalid), 64'd0);
      check("midrst_err", {63'd0, err}, 64'd0);

      // Unsolicited DES valid with nothing in flight
      out_ready = 1'b0;
      step();
      inj_dv = 1'b1; inj_data = 64'hDEADBEEFCAFEF00D;
      exp_q.push_back(inj_data);
      step();
      inj_dv = 1'b0;
      @(negedge clk);
      check("spur_err", {63'd0, err}, 64'd1);
      check("spur_valid", {63'd0, out_valid}, 64'd1);
      check("spur_data", out_data, 64'hDEADBEEFCAFEF00D);

      // Top up to full behind the spurious word, then push and pop together
      a0 = acc_cnt;
      in_valid = 1'b1;
      repeat (40) step();
      in_valid = 1'b0;
      check("top_accepts", 64'(acc_cnt - a0), 64'd31);
      wait_count(32, "top_full_count");
      check("full_data_stable", out_data, 64'hDEADBEEFCAFEF00D);
      step();
      inj_dv = 1'b1; inj_data = 64'h1122334455667788; out_ready = 1'b1;
      exp_q.push_back(inj_data);
      step();
      inj_dv = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      check("pushpop_count", {{(64-CW){1'b0}}, count}, 64'd32);
      step();
      out_ready = 1'b1;
      wait_count(0, "final_drain_count");
      repeat (3) step();
      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Hard bound on run time
   initial begin
      #500000;
      $display("FAIL timeout: simulation did not complete, expected finish");
      $fatal(1, "timeout");
   end

endmodule
